// File: rtl/ddr_pixel_packer.sv
// rtl/ddr_pixel_packer.sv - streams nine per-direction BRAMs as 144-bit pixel beats
// Optional build macro PIXEL_PACK_SOF_EN adds m00_axis_tuser marking pixel 0.
module ddr_pixel_packer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                       m00_axis_aclk,
    input  logic                       m00_axis_aresetn,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [ADDRESS_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]      n_q,
    input  logic [DATA_WIDTH-1:0]      null_q,
    input  logic [DATA_WIDTH-1:0]      ne_q,
    input  logic [DATA_WIDTH-1:0]      e_q,
    input  logic [DATA_WIDTH-1:0]      se_q,
    input  logic [DATA_WIDTH-1:0]      s_q,
    input  logic [DATA_WIDTH-1:0]      sw_q,
    input  logic [DATA_WIDTH-1:0]      w_q,
    input  logic [DATA_WIDTH-1:0]      nw_q,
    output logic                       m00_axis_tvalid,
    output logic [9*DATA_WIDTH-1:0]    m00_axis_tdata,
    output logic                       m00_axis_tlast,
`ifdef PIXEL_PACK_SOF_EN
    output logic                       m00_axis_tuser,
`endif
    output logic [9*DATA_WIDTH/8-1:0]  m00_axis_tstrb,
    input  logic                       m00_axis_tready
);
    localparam int BW = 9 * DATA_WIDTH;
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      issued;
    logic               inflight;
    logic               inflight_last;
    logic [1:0]         occ;
    logic               wr_ptr, rd_ptr;
    logic [1:0][BW-1:0] mem_data;
    logic [1:0]         mem_last;
    logic               pop, frame_start;
`ifdef PIXEL_PACK_SOF_EN
    logic               inflight_first;
    logic [1:0]         mem_first;
`endif

    assign pop             = m00_axis_tvalid && m00_axis_tready;
    assign m00_axis_tvalid = (occ != 2'd0);
    assign m00_axis_tdata  = mem_data[rd_ptr];
    assign m00_axis_tlast  = m00_axis_tvalid && mem_last[rd_ptr];
    assign m00_axis_tstrb  = '1;
`ifdef PIXEL_PACK_SOF_EN
    assign m00_axis_tuser  = m00_axis_tvalid && mem_first[rd_ptr];
`endif
    assign busy = (state == RUN);
    assign done = (state == DONE_S);

    // Credit rule: buffered + in-flight reads after this cycle's pop must stay below 2.
    always_comb begin
        state_nxt   = state;
        rd_en       = 1'b0;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                rd_en = (issued < DEPTH_C) &&
                        (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
                if (pop && m00_axis_tlast) begin
                    state_nxt = DONE_S;
                end
            end
            DONE_S:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state         <= IDLE;
            issued        <= '0;
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
`ifdef PIXEL_PACK_SOF_EN
            inflight_first <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            inflight      <= rd_en;
            inflight_last <= rd_en && (issued == LAST_C);
`ifdef PIXEL_PACK_SOF_EN
            inflight_first <= rd_en && (issued == '0);
`endif
            if (frame_start) begin
                issued  <= '0;
                rd_addr <= '0;
            end else if (rd_en) begin
                issued  <= issued + CW'(1);
                rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
            end
        end
    end

    // Two-entry skid buffer; the BRAM word arriving this cycle belongs to last cycle's read.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            mem_data <= '0;
            mem_last <= '0;
`ifdef PIXEL_PACK_SOF_EN
            mem_first <= '0;
`endif
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            if (inflight) begin
                mem_data[wr_ptr] <= {nw_q, w_q, sw_q, s_q, se_q, e_q, ne_q, null_q, n_q};
                mem_last[wr_ptr] <= inflight_last;
`ifdef PIXEL_PACK_SOF_EN
                mem_first[wr_ptr] <= inflight_first;
`endif
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_pixel_packer.sv
// tb/tb_ddr_pixel_packer.sv - randomized self-checking bench for ddr_pixel_packer
// Three instances: DEPTH 2500 (main scenarios), DEPTH 1 and DEPTH 4096 (boundaries).
module tb_ddr_pixel_packer;
    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  tready_v;
    logic [2:0]  busy_v, done_v, rd_en_v, tvalid_v, tlast_v;
    logic [11:0] rd_addr_v [3];
    logic [143:0] tdata_v [3];
    logic [17:0] tstrb_v [3];
    logic [15:0] q_v [3][9];
`ifdef PIXEL_PACK_SOF_EN
    logic [2:0]  tuser_v;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int phase [3], iss [3], hs [3], lag [3], frames [3];
    int start_cyc [3], done_cyc [3], first_hs [3], last_hs [3], last_addr [3];
    logic stall [3];
    logic held_last [3];
    logic [143:0] held_data [3];

    function automatic int dep(input int g);
        return (g == 0) ? 2500 : ((g == 1) ? 1 : 4096);
    endfunction

    function automatic logic [143:0] pixel(input int idx);
        logic [143:0] v;
        v = '0;
        for (int d = 0; d < 9; d++) v[d*16 +: 16] = 16'(idx + d);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        ddr_pixel_packer #(
            .DATA_WIDTH(16),
            .DEPTH((g == 0) ? 2500 : ((g == 1) ? 1 : 4096)),
            .ADDRESS_WIDTH(12)
        ) dut (
            .m00_axis_aclk(clk),
            .m00_axis_aresetn(rst_n),
            .start(start_v[g]),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .rd_en(rd_en_v[g]),
            .rd_addr(rd_addr_v[g]),
            .n_q(q_v[g][0]),
            .null_q(q_v[g][1]),
            .ne_q(q_v[g][2]),
            .e_q(q_v[g][3]),
            .se_q(q_v[g][4]),
            .s_q(q_v[g][5]),
            .sw_q(q_v[g][6]),
            .w_q(q_v[g][7]),
            .nw_q(q_v[g][8]),
            .m00_axis_tvalid(tvalid_v[g]),
            .m00_axis_tdata(tdata_v[g]),
            .m00_axis_tlast(tlast_v[g]),
`ifdef PIXEL_PACK_SOF_EN
            .m00_axis_tuser(tuser_v[g]),
`endif
            .m00_axis_tstrb(tstrb_v[g]),
            .m00_axis_tready(tready_v[g])
        );
    end

    // BRAM: direction d at address a holds a + d, one cycle read latency.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++)
            for (int d = 0; d < 9; d++)
                if (rd_en_v[g]) q_v[g][d] <= 16'(rd_addr_v[g] + d);
    end

    // Reference model in counts: reads issued, beats accepted, reads captured two cycles later.
    initial begin
        for (int g = 0; g < 3; g++) begin
            phase[g] = 0; iss[g] = 0; hs[g] = 0; lag[g] = 0; frames[g] = 0;
            stall[g] = 1'b0; held_data[g] = '0; held_last[g] = 1'b0;
            start_cyc[g] = 0; done_cyc[g] = 0; first_hs[g] = 0; last_hs[g] = 0; last_addr[g] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 3; g++) begin
                int dd, cap, pop, exp_rd;
                dd = dep(g);
                if (!rst_n) begin
                    chk($sformatf("rst_tvalid%0d", g), tvalid_v[g], 0);
                    chk($sformatf("rst_busy%0d", g), busy_v[g], 0);
                    chk($sformatf("rst_rd_en%0d", g), rd_en_v[g], 0);
                    chk($sformatf("rst_done%0d", g), done_v[g], 0);
                    phase[g] = 0; iss[g] = 0; hs[g] = 0; lag[g] = 0; stall[g] = 1'b0;
                    continue;
                end
                chk($sformatf("busy%0d", g), busy_v[g], phase[g] == 1);
                chk($sformatf("done%0d", g), done_v[g], phase[g] == 2);
                if (done_v[g]) begin
                    frames[g]++;
                    done_cyc[g] = cyc;
                end
                chk($sformatf("tstrb%0d", g), tstrb_v[g], 18'h3ffff);
                cap = lag[g];
                lag[g] = iss[g];
                chk($sformatf("tvalid%0d", g), tvalid_v[g], (cap - hs[g]) > 0);
                if (stall[g]) begin
                    chk($sformatf("hold_data%0d", g), tdata_v[g], held_data[g]);
                    chk($sformatf("hold_last%0d", g), tlast_v[g], held_last[g]);
                end
                pop = (tvalid_v[g] && tready_v[g]) ? 1 : 0;
                exp_rd = (phase[g] == 1 && iss[g] < dd && (iss[g] - hs[g] - pop) < 2) ? 1 : 0;
                chk($sformatf("rd_en%0d", g), rd_en_v[g], exp_rd);
                if (rd_en_v[g]) begin
                    chk($sformatf("rd_addr%0d", g), rd_addr_v[g], iss[g] % 4096);
                    last_addr[g] = rd_addr_v[g];
                    iss[g]++;
                end
                chk($sformatf("credit%0d", g), (iss[g] - hs[g] - pop) <= 2, 1);
                if (pop != 0) begin
                    chk($sformatf("tdata%0d", g), tdata_v[g], pixel(hs[g]));
                    chk($sformatf("tlast%0d", g), tlast_v[g], hs[g] == dd - 1);
`ifdef PIXEL_PACK_SOF_EN
                    chk($sformatf("tuser%0d", g), tuser_v[g], hs[g] == 0);
`endif
                    if (g == 0 && hs[g] == 1) begin
                        chk("lit_beat1_n", tdata_v[g][15:0], 16'd1);
                        chk("lit_beat1_nw", tdata_v[g][143:128], 16'd9);
                    end
                    if (hs[g] == 0) first_hs[g] = cyc;
                    last_hs[g] = cyc;
                    hs[g]++;
                end
                stall[g] = tvalid_v[g] && !tready_v[g];
                held_data[g] = tdata_v[g];
                held_last[g] = tlast_v[g];
                case (phase[g])
                    0: if (start_v[g]) begin
                        phase[g] = 1; iss[g] = 0; hs[g] = 0; lag[g] = 0; start_cyc[g] = cyc;
                    end
                    1: if (pop != 0 && hs[g] == dd) phase[g] = 2;
                    default: phase[g] = 0;
                endcase
            end
        end
    end

    task automatic wait_frames(input int g, input int tgt, input int budget, input logic rnd);
        int n;
        n = 0;
        while (frames[g] < tgt && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) tready_v[g] = 1'($urandom_range(0, 1));
            n++;
        end
        chk($sformatf("timeout%0d", g), n < budget, 1);
    endtask

    task automatic pulse_start(input logic [2:0] m);
        @(posedge clk);
        #1 start_v = m;
        @(posedge clk);
        #1 start_v = 3'b000;
    endtask

    initial begin
        int tgt [3];
        int n;
        rst_n = 1'b0;
        start_v = 3'b000;
        tready_v = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tdata", tdata_v[0], 0);
        chk("rst_rd_addr", rd_addr_v[0], 0);
        rst_n = 1'b1;

        // Continuous ready on all three depths at once.
        for (int g = 0; g < 3; g++) tgt[g] = frames[g] + 1;
        tready_v = 3'b111;
        pulse_start(3'b111);
        for (int g = 0; g < 3; g++) wait_frames(g, tgt[g], 6000, 1'b0);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("done_lat%0d", g), done_cyc[g] - start_cyc[g], dep(g) + 3);
            chk($sformatf("first_lat%0d", g), first_hs[g] - start_cyc[g], 3);
            chk($sformatf("burst%0d", g), last_hs[g] - first_hs[g], dep(g) - 1);
            chk($sformatf("beats%0d", g), hs[g], dep(g));
        end
        chk("lit_done_lat_2500", done_cyc[0] - start_cyc[0], 2503);
        chk("lit_depth1_beats", hs[1], 1);
        chk("lit_last_addr_4096", last_addr[2], 4095);

        // Random 50% ready.
        tgt[0] = frames[0] + 1;
        pulse_start(3'b001);
        wait_frames(0, tgt[0], 20000, 1'b1);
        chk("rand_beats", hs[0], 2500);

        // Stall 100 cycles from the first valid beat, then release.
        tready_v[0] = 1'b0;
        tgt[0] = frames[0] + 1;
        pulse_start(3'b001);
        n = 0;
        while (!tvalid_v[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_first_valid", n < 10, 1);
        repeat (100) @(posedge clk);
        #1;
        chk("stall_issued", iss[0], 2);
        chk("stall_rd_en", rd_en_v[0], 0);
        chk("stall_beats", hs[0], 0);
        tready_v[0] = 1'b1;
        wait_frames(0, tgt[0], 6000, 1'b0);
        chk("release_burst", last_hs[0] - first_hs[0], 2499);

        // Start during RUN is ignored; a later start repeats the frame.
        tgt[0] = frames[0] + 1;
        pulse_start(3'b001);
        repeat (50) @(posedge clk);
        pulse_start(3'b001);
        wait_frames(0, tgt[0], 6000, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("one_frame", frames[0], tgt[0]);
        chk("idle_after", busy_v[0], 0);
        tgt[0] = frames[0] + 1;
        pulse_start(3'b001);
        wait_frames(0, tgt[0], 6000, 1'b0);
        chk("repeat_beats", hs[0], 2500);

        // Asynchronous reset around beat 1000, then a fresh frame.
        pulse_start(3'b001);
        n = 0;
        while (hs[0] < 1000 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("reach_1000", n < 3000, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_tvalid", tvalid_v[0], 0);
        chk("async_busy", busy_v[0], 0);
        chk("async_rd_en", rd_en_v[0], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tgt[0] = frames[0] + 1;
        pulse_start(3'b001);
        wait_frames(0, tgt[0], 6000, 1'b0);
        chk("post_reset_beats", hs[0], 2500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
